fft_stage_repacker: RTL

- Write side of the 24-bit unified sample format: [23:16] FP8 real, [15:8] FP8 imag, [7:4] FP4 real, [3:0] FP4 imag.
- Takes one butterfly result pair (X, Y) per handshake, together with its precision flag.
- Fills both precision fields of each output word: FP4→FP8 up-conversion is exact; FP8→FP4 down-conversion uses round-to-nearest-even (RNE) with saturation.
- Serialises X then Y onto a valid/ready stream that feeds the next FFT stage.

---
 rtl/fft_fmt_pkg.sv | 37 +++
 rtl/fp_precision_convert.sv | 58 +++++
 rtl/fft_stage_repacker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft_fmt_pkg.sv
// Shared constants and types for the 24-bit unified FFT sample format:
// [23:16] FP8 real, [15:8] FP8 imag, [7:4] FP4 real, [3:0] FP4 imag.
package fft_fmt_pkg;

  localparam int unsigned FP4_W = 4;
  localparam int unsigned FP8_W = 8;
  localparam int unsigned UNI_W = 24;

  localparam int unsigned UNI_FP8_RE_HI = 23;
  localparam int unsigned UNI_FP8_RE_LO = 16;
  localparam int unsigned UNI_FP8_IM_HI = 15;
  localparam int unsigned UNI_FP8_IM_LO = 8;
  localparam int unsigned UNI_FP4_RE_HI = 7;
  localparam int unsigned UNI_FP4_RE_LO = 4;
  localparam int unsigned UNI_FP4_IM_HI = 3;
  localparam int unsigned UNI_FP4_IM_LO = 0;

  localparam int unsigned FP8_BIAS = 7;
  localparam int unsigned FP4_BIAS = 1;
  localparam logic [2:0] FP4_MAX_MAG = 3'b111;

  typedef enum logic [1:0] {EMPTY, SEND_X, SEND_Y} state_e;

  function automatic logic [UNI_W-1:0] pack_uni(input logic [FP8_W-1:0] re8,
                                                input logic [FP8_W-1:0] im8,
                                                input logic [FP4_W-1:0] re4,
                                                input logic [FP4_W-1:0] im4);
    logic [UNI_W-1:0] w;
    w = '0;
    w[UNI_FP8_RE_HI:UNI_FP8_RE_LO] = re8;
    w[UNI_FP8_IM_HI:UNI_FP8_IM_LO] = im8;
    w[UNI_FP4_RE_HI:UNI_FP4_RE_LO] = re4;
    w[UNI_FP4_IM_HI:UNI_FP4_IM_LO] = im4;
    return w;
  endfunction

endpackage

// File: rtl/fp_precision_convert.sv
// Single-component FP4 (E2M1) <-> FP8 (E4M3) converter. Up-conversion is exact;
// down-conversion rounds to nearest even and saturates to +/-6, flagging sat_o.
module fp_precision_convert
  import fft_fmt_pkg::*;
(
  input  logic [FP4_W-1:0] fp4_i,
  input  logic [FP8_W-1:0] fp8_i,
  output logic [FP8_W-1:0] fp8_o,
  output logic [FP4_W-1:0] fp4_o,
  output logic             sat_o
);

  // FP8 magnitude thresholds in units of 2^-9 (the smallest FP8 subnormal).
  // Strict '>' where the tie rounds down to the even code, '>=' where it rounds up.
  localparam logic [17:0] T_0P25 = 18'd128;
  localparam logic [17:0] T_0P75 = 18'd384;
  localparam logic [17:0] T_1P25 = 18'd640;
  localparam logic [17:0] T_1P75 = 18'd896;
  localparam logic [17:0] T_2P5  = 18'd1280;
  localparam logic [17:0] T_3P5  = 18'd1792;
  localparam logic [17:0] T_5P0  = 18'd2560;
  localparam logic [17:0] T_6P0  = 18'd3072;

  localparam logic [3:0] EXP_ADJ = 4'(FP8_BIAS - FP4_BIAS);

  always_comb begin
    fp8_o = '0;
    if (fp4_i[2:0] == 3'b000) begin
      fp8_o = {fp4_i[3], 7'b0};
    end else if (fp4_i[2:1] == 2'b00) begin
      fp8_o = {fp4_i[3], EXP_ADJ, 3'b000};
    end else begin
      fp8_o = {fp4_i[3], 4'(fp4_i[2:1]) + EXP_ADJ, fp4_i[0], 2'b00};
    end
  end

  logic [3:0]  exp8;
  logic [2:0]  man8;
  logic [17:0] mag;
  logic        nan;
  logic [2:0]  code;

  always_comb begin
    exp8 = fp8_i[6:3];
    man8 = fp8_i[2:0];
    if (exp8 == 4'd0) begin
      mag = {15'b0, man8};
    end else begin
      mag = {14'b0, 1'b1, man8} << (exp8 - 4'd1);
    end
    nan   = &fp8_i[6:0];
    code  = 3'(mag > T_0P25) + 3'(mag >= T_0P75) + 3'(mag > T_1P25) + 3'(mag >= T_1P75)
          + 3'(mag > T_2P5) + 3'(mag >= T_3P5) + 3'(mag > T_5P0);
    sat_o = nan | (mag > T_6P0);
    fp4_o = {fp8_i[7], sat_o ? FP4_MAX_MAG : code};
  end

endmodule

// File: rtl/fft_stage_repacker.sv
// Repacks one butterfly pair (X, Y) into two unified words and streams X then Y.
// Optional saturation statistics counter enabled by FFT_STAGE_REPACK_STATS_EN.
module fft_stage_repacker
  import fft_fmt_pkg::*;
#(
  parameter int unsigned FRAME_PAIRS = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  input  logic             in_is_fp8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [UNI_W-1:0] out_data,
  output logic             out_is_y,
  output logic             out_src_fp8,
  output logic             out_frame_end
`ifdef FFT_STAGE_REPACK_STATS_EN
  ,
  output logic [CNT_W-1:0] sat_count
`endif
);

  localparam int unsigned PCNT_W = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
  localparam logic [PCNT_W-1:0] LAST_PAIR = PCNT_W'(FRAME_PAIRS - 1);

  // Component order: 0 = X imag, 1 = X real, 2 = Y imag, 3 = Y real.
  logic [3:0][FP8_W-1:0] src8;
  logic [3:0][FP4_W-1:0] src4;
  logic [3:0][FP8_W-1:0] up8;
  logic [3:0][FP4_W-1:0] dn4;
  logic [3:0]            sat;

  assign src8 = {in_y[15:8], in_y[7:0], in_x[15:8], in_x[7:0]};
  assign src4 = {in_y[7:4], in_y[3:0], in_x[7:4], in_x[3:0]};

  for (genvar i = 0; i < 4; i++) begin : g_conv
    fp_precision_convert u_conv (
      .fp4_i (src4[i]),
      .fp8_i (src8[i]),
      .fp8_o (up8[i]),
      .fp4_o (dn4[i]),
      .sat_o (sat[i])
    );
  end

  logic [UNI_W-1:0] x_word;
  logic [UNI_W-1:0] y_word;

  always_comb begin
    if (in_is_fp8) begin
      x_word = pack_uni(in_x[15:8], in_x[7:0], dn4[1], dn4[0]);
      y_word = pack_uni(in_y[15:8], in_y[7:0], dn4[3], dn4[2]);
    end else begin
      x_word = pack_uni(up8[1], up8[0], in_x[7:4], in_x[3:0]);
      y_word = pack_uni(up8[3], up8[2], in_y[7:4], in_y[3:0]);
    end
  end

  state_e            state_q;
  logic              out_valid_q;
  logic [UNI_W-1:0]  out_data_q;
  logic [UNI_W-1:0]  y_word_q;
  logic              out_is_y_q;
  logic              out_src_fp8_q;
  logic              out_frame_end_q;
  logic [PCNT_W-1:0] pair_cnt_q;

  logic accept;
  logic out_hs;

  assign in_ready = (state_q == EMPTY) | ((state_q == SEND_Y) & out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  // An accept in SEND_Y coincides with the Y handshake, so its load overrides the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= EMPTY;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      y_word_q        <= '0;
      out_is_y_q      <= 1'b0;
      out_src_fp8_q   <= 1'b0;
      out_frame_end_q <= 1'b0;
      pair_cnt_q      <= '0;
    end else begin
      if (out_hs && (state_q == SEND_X)) begin
        state_q         <= SEND_Y;
        out_data_q      <= y_word_q;
        out_is_y_q      <= 1'b1;
        out_frame_end_q <= (pair_cnt_q == LAST_PAIR);
      end
      if (out_hs && (state_q == SEND_Y)) begin
        state_q         <= EMPTY;
        out_valid_q     <= 1'b0;
        out_is_y_q      <= 1'b0;
        out_frame_end_q <= 1'b0;
        pair_cnt_q      <= (pair_cnt_q == LAST_PAIR) ? '0 : pair_cnt_q + PCNT_W'(1);
      end
      if (accept) begin
        state_q         <= SEND_X;
        out_valid_q     <= 1'b1;
        out_data_q      <= x_word;
        y_word_q        <= y_word;
        out_is_y_q      <= 1'b0;
        out_src_fp8_q   <= in_is_fp8;
        out_frame_end_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_is_y      = out_is_y_q;
  assign out_src_fp8   = out_src_fp8_q;
  assign out_frame_end = out_frame_end_q;

`ifdef FFT_STAGE_REPACK_STATS_EN
  logic [2:0]       sat_inc;
  logic [CNT_W:0]   sat_sum;
  logic [CNT_W-1:0] sat_count_q;

  always_comb begin
    sat_inc = '0;
    if (in_is_fp8) begin
      sat_inc = 3'(sat[0]) + 3'(sat[1]) + 3'(sat[2]) + 3'(sat[3]);
    end
    sat_sum = {1'b0, sat_count_q} + (CNT_W + 1)'(sat_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_q <= '0;
    end else if (accept) begin
      sat_count_q <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    end
  end

  assign sat_count = sat_count_q;
`else
  logic [CNT_W-1:0] unused_stats;
  assign unused_stats = CNT_W'(sat);
`endif

endmodule
